// File: rtl/rs_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rs_encoder_pkg
//  Description : Shared Reed-Solomon code parameters, byte/position types and
//                GF(2^8) helpers: a constant multiplier and a table of alpha
//                powers used to derive the syndrome root constants.
//  Revision    : 1.0  initial release
// ============================================================================
package rs_encoder_pkg;

   // Code geometry: RS(255,223) over GF(2^8)
   localparam int unsigned RS_K            = 223;
   localparam int unsigned RS_PARITY_BYTES = 32;
   localparam int unsigned RS_N            = RS_K + RS_PARITY_BYTES;
   // First consecutive root exponent of the generator polynomial
   localparam int unsigned RS_FCR          = 1;
   // Field polynomial x^8 + x^4 + x^3 + x^2 + 1
   localparam logic [8:0]  RS_GF_POLY      = 9'h11D;

   localparam int unsigned RS_POS_W        = $clog2(RS_N);
   localparam int unsigned RS_NZ_W         = $clog2(RS_PARITY_BYTES + 1);

   typedef logic [7:0]          rs_byte_t;
   typedef logic [RS_POS_W-1:0] rs_pos_t;
   typedef logic [RS_NZ_W-1:0]  rs_nz_t;
   // alpha^e for e = 0..254, entry e at index e
   typedef logic [254:0][7:0]   rs_alpha_tab_t;

   // Multiply by alpha (x) with reduction by the field polynomial
   function automatic rs_byte_t gf_xtime(input rs_byte_t a);
      rs_byte_t r;
      r = {a[6:0], 1'b0};
      if (a[7]) begin
         r = r ^ RS_GF_POLY[7:0];
      end
      return r;
   endfunction

   // General GF(2^8) multiply, shift-and-add
   function automatic rs_byte_t gf_mul(input rs_byte_t a, input rs_byte_t b);
      rs_byte_t acc;
      rs_byte_t x;
      acc = '0;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            acc = acc ^ x;
         end
         x = gf_xtime(x);
      end
      return acc;
   endfunction

   // Build the alpha power table at elaboration time
   function automatic rs_alpha_tab_t gf_gen_alpha_tab();
      rs_alpha_tab_t t;
      rs_byte_t      x;
      x = 8'h01;
      for (int e = 0; e < 255; e++) begin
         t[e] = x;
         x    = gf_xtime(x);
      end
      return t;
   endfunction

   localparam rs_alpha_tab_t RS_ALPHA_POW = gf_gen_alpha_tab();

endpackage
`default_nettype wire

// File: rtl/rs_syndrome_cell.sv
`default_nettype none
// ============================================================================
//  Module      : rs_syndrome_cell
//  Description : One Horner syndrome accumulator S = S*alpha^ROOT_EXP ^ byte.
//                syn_next_o is the value including the current byte so the
//                parent can capture a block's final syndrome on the same
//                edge that clears the accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_syndrome_cell
   import rs_encoder_pkg::*;
#(
   parameter int unsigned ROOT_EXP = 1
)
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     en_i,
   input  logic     clr_i,
   input  rs_byte_t data_i,
   output rs_byte_t syn_next_o
);

   localparam rs_byte_t c_ROOT = RS_ALPHA_POW[ROOT_EXP % 255];

   rs_byte_t syn_q;
   rs_byte_t syn_d;

   // Horner step: fold the incoming byte into the running evaluation
   always_comb begin
      syn_d = gf_mul(syn_q, c_ROOT) ^ data_i;
   end

   // Accumulator register; a block-end byte restarts it from zero
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         syn_q <= '0;
      end else if (en_i) begin
         syn_q <= clr_i ? '0 : syn_d;
      end
   end

   assign syn_next_o = syn_d;

endmodule
`default_nettype wire

// File: rtl/rs_syndrome_check.sv
`default_nettype none
// ============================================================================
//  Module      : rs_syndrome_check
//  Description : Streams RS codewords, computes all syndromes with one
//                Horner cell per root, forwards message (and optionally
//                parity) bytes through a single output register and reports
//                per-block error status (any nonzero / count nonzero).
//                Optional macro RS_FRAME_CHECK_EN adds a framing-violation
//                flag (m_stat_frame_err) checking sop/is_parity/last tags.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_syndrome_check
   import rs_encoder_pkg::*;
#(
   parameter bit DROP_PARITY = 1'b1
)
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     s_axis_valid,
   output logic     s_axis_ready,
   input  rs_byte_t s_axis_data,
   input  logic     s_axis_last,
   input  logic     s_axis_sop,
   input  logic     s_axis_is_parity,
   output logic     m_axis_valid,
   input  logic     m_axis_ready,
   output rs_byte_t m_axis_data,
   output logic     m_axis_last,
   output logic     m_axis_sop,
   output logic     m_axis_is_parity,
   output logic     m_stat_valid,
   input  logic     m_stat_ready,
   output logic     m_stat_err,
`ifdef RS_FRAME_CHECK_EN
   output logic     m_stat_frame_err,
`endif
   output rs_nz_t   m_stat_nz_cnt
);

   localparam rs_pos_t c_LAST_POS  = rs_pos_t'(RS_N - 1);
   localparam rs_pos_t c_FIRST_PAR = rs_pos_t'(RS_K);
   localparam rs_pos_t c_LAST_FWD  = DROP_PARITY ? rs_pos_t'(RS_K - 1) : c_LAST_POS;

   logic     run_q;
   rs_pos_t  pos_q;
   rs_pos_t  pos_d;

   logic     w_in_hs;
   logic     w_blk_end;
   logic     w_is_par;
   logic     w_fwd;

   rs_byte_t w_syn_next [RS_PARITY_BYTES];
   rs_nz_t   w_nz;
   logic     w_err;

   logic     m_valid_q;
   rs_byte_t m_data_q;
   logic     m_last_q;
   logic     m_sop_q;
   logic     m_par_q;

   logic     stat_valid_q;
   logic     stat_err_q;
   rs_nz_t   stat_nz_q;

   // Input accepted only when the output slot frees up and no status waits
   assign s_axis_ready = run_q && (!m_valid_q || m_axis_ready) && !stat_valid_q;
   assign w_in_hs      = s_axis_valid && s_axis_ready;
   assign w_blk_end    = (pos_q == c_LAST_POS);
   assign w_is_par     = (pos_q >= c_FIRST_PAR);
   assign w_fwd        = w_in_hs && (!DROP_PARITY || !w_is_par);

   // Keep input closed for the first cycle after reset release
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   // Next byte position: advance per accepted byte, wrap after the last one
   always_comb begin
      pos_d = pos_q;
      if (w_in_hs) begin
         pos_d = w_blk_end ? '0 : pos_q + rs_pos_t'(1);
      end
   end

   // Byte position register
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end

   for (genvar j = 0; j < RS_PARITY_BYTES; j++) begin : g_cells
      rs_syndrome_cell #(
         .ROOT_EXP (RS_FCR + j)
      ) u_cell (
         .clk        (clk),
         .rst_n      (rst_n),
         .en_i       (w_in_hs),
         .clr_i      (w_blk_end),
         .data_i     (s_axis_data),
         .syn_next_o (w_syn_next[j])
      );
   end

   // Count syndromes that would be nonzero after the current byte
   always_comb begin
      w_nz = '0;
      for (int j = 0; j < RS_PARITY_BYTES; j++) begin
         if (w_syn_next[j] != '0) begin
            w_nz = w_nz + rs_nz_t'(1);
         end
      end
   end

   assign w_err = (w_nz != '0);

   // Single output register; holds its content while the sink stalls
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_sop_q   <= 1'b0;
         m_par_q   <= 1'b0;
      end else if (w_fwd) begin
         m_valid_q <= 1'b1;
         m_data_q  <= s_axis_data;
         m_last_q  <= (pos_q == c_LAST_FWD);
         m_sop_q   <= (pos_q == '0);
         m_par_q   <= w_is_par;
      end else if (m_axis_ready) begin
         m_valid_q <= 1'b0;
      end
   end

   assign m_axis_valid     = m_valid_q;
   assign m_axis_data      = m_data_q;
   assign m_axis_last      = m_last_q;
   assign m_axis_sop       = m_sop_q;
   assign m_axis_is_parity = m_par_q;

   // Capture block status on the final byte, release it on the handshake
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         stat_valid_q <= 1'b0;
         stat_err_q   <= 1'b0;
         stat_nz_q    <= '0;
      end else if (w_in_hs && w_blk_end) begin
         stat_valid_q <= 1'b1;
         stat_err_q   <= w_err;
         stat_nz_q    <= w_nz;
      end else if (stat_valid_q && m_stat_ready) begin
         stat_valid_q <= 1'b0;
      end
   end

   assign m_stat_valid  = stat_valid_q;
   assign m_stat_err    = stat_err_q;
   assign m_stat_nz_cnt = stat_nz_q;

`ifdef RS_FRAME_CHECK_EN
   logic frame_q;
   logic stat_frame_q;
   logic w_frame_bad;

   // Any tag disagreeing with the position-derived framing is a violation
   assign w_frame_bad = (s_axis_sop       != (pos_q == '0)) ||
                        (s_axis_is_parity != w_is_par)      ||
                        (s_axis_last      != w_blk_end);

   // Sticky violation flag per block, handed to the status on block end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         frame_q      <= 1'b0;
         stat_frame_q <= 1'b0;
      end else if (w_in_hs) begin
         if (w_blk_end) begin
            stat_frame_q <= frame_q || w_frame_bad;
            frame_q      <= 1'b0;
         end else begin
            frame_q      <= frame_q || w_frame_bad;
         end
      end
   end

   assign m_stat_frame_err = stat_frame_q;
`else
   // Framing tags carry no meaning when the checker is not built
   logic w_unused_tags;
   assign w_unused_tags = s_axis_sop ^ s_axis_is_parity ^ s_axis_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_syndrome_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_syndrome_check
//  Description : Self-checking bench for rs_syndrome_check. Builds codewords
//                with a systematic RS encoder, predicts status from a
//                power-sum syndrome evaluation and scoreboards both streams.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_syndrome_check;
   import rs_encoder_pkg::*;

   localparam int N       = RS_K + RS_PARITY_BYTES;
   localparam int K       = RS_K;
   localparam int P       = RS_PARITY_BYTES;
   localparam bit TB_DROP = 1'b1;
   localparam int N_RAND  = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_axis_valid = 1'b0;
   logic       s_axis_ready;
   logic [7:0] s_axis_data = 8'h00;
   logic       s_axis_last = 1'b0;
   logic       s_axis_sop = 1'b0;
   logic       s_axis_is_parity = 1'b0;
   logic       m_axis_valid;
   logic       m_axis_ready;
   logic [7:0] m_axis_data;
   logic       m_axis_last;
   logic       m_axis_sop;
   logic       m_axis_is_parity;
   logic       m_stat_valid;
   logic       m_stat_ready;
   logic       m_stat_err;
   rs_nz_t     m_stat_nz_cnt;
   logic       tb_ferr;

   logic stall_en = 1'b0;
   logic man_axis_rdy = 1'b1;
   logic man_stat_rdy = 1'b1;
   logic rnd_axis_rdy = 1'b1;
   logic rnd_stat_rdy = 1'b1;
   assign m_axis_ready = stall_en ? rnd_axis_rdy : man_axis_rdy;
   assign m_stat_ready = stall_en ? rnd_stat_rdy : man_stat_rdy;

   always #5 clk = ~clk;

`ifdef RS_FRAME_CHECK_EN
   logic m_stat_frame_err;
   assign tb_ferr = m_stat_frame_err;
`else
   assign tb_ferr = 1'b0;
`endif

   rs_syndrome_check #(.DROP_PARITY(TB_DROP)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_axis_valid     (s_axis_valid),
      .s_axis_ready     (s_axis_ready),
      .s_axis_data      (s_axis_data),
      .s_axis_last      (s_axis_last),
      .s_axis_sop       (s_axis_sop),
      .s_axis_is_parity (s_axis_is_parity),
      .m_axis_valid     (m_axis_valid),
      .m_axis_ready     (m_axis_ready),
      .m_axis_data      (m_axis_data),
      .m_axis_last      (m_axis_last),
      .m_axis_sop       (m_axis_sop),
      .m_axis_is_parity (m_axis_is_parity),
      .m_stat_valid     (m_stat_valid),
      .m_stat_ready     (m_stat_ready),
      .m_stat_err       (m_stat_err),
`ifdef RS_FRAME_CHECK_EN
      .m_stat_frame_err (m_stat_frame_err),
`endif
      .m_stat_nz_cnt    (m_stat_nz_cnt)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed { logic [7:0] d; logic sop; logic par; logic last; } fwd_t;
   typedef struct packed { logic err; logic [7:0] nz; logic ferr; } stat_t;
   typedef struct { bit rnd; int flip_pos; logic [7:0] mask; logic err; int nz; } vec_t;

   fwd_t  exp_fwd[$];
   stat_t exp_stat[$];
   int    stat_seen = 0;
   bit    mon_ignore = 1'b0;

   logic [7:0] gexp [255];
   int         glog [256];
   logic [7:0] genp [P+1];
   logic [7:0] blk  [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return gexp[(glog[a] + glog[b]) % 255];
   endfunction

   // log/antilog tables and generator polynomial prod (x + alpha^(FCR+r))
   task automatic init_gf();
      logic [8:0] x;
      logic [7:0] root;
      x = 9'h001;
      for (int e = 0; e < 255; e++) begin
         gexp[e] = x[7:0];
         glog[x[7:0]] = e;
         x = x << 1;
         if (x[8]) x = x ^ RS_GF_POLY;
      end
      for (int k = 0; k <= P; k++) genp[k] = 8'h00;
      genp[0] = 8'h01;
      for (int r = 0; r < P; r++) begin
         root = gexp[(RS_FCR + r) % 255];
         for (int k = r + 1; k >= 1; k--) genp[k] = genp[k-1] ^ gmul(genp[k], root);
         genp[0] = gmul(genp[0], root);
      end
   endtask

   // Systematic encode: message first, then remainder of m(x)x^P mod g(x)
   task automatic encode(input bit rnd);
      logic [7:0] rem [P];
      logic [7:0] fb;
      for (int k = 0; k < P; k++) rem[k] = 8'h00;
      for (int i = 0; i < K; i++) begin
         blk[i] = rnd ? 8'($urandom) : 8'h00;
         fb = blk[i] ^ rem[P-1];
         for (int k = P - 1; k >= 1; k--) rem[k] = rem[k-1] ^ gmul(fb, genp[k]);
         rem[0] = gmul(fb, genp[0]);
      end
      for (int k = 0; k < P; k++) blk[K+k] = rem[P-1-k];
   endtask

   // Reference: S_j = sum_i c_i * alpha^((FCR+j)*(N-1-i)), evaluated directly
   function automatic stat_t model_status();
      stat_t      s;
      logic [7:0] acc;
      s = '0;
      for (int j = 0; j < P; j++) begin
         acc = 8'h00;
         for (int i = 0; i < N; i++)
            acc = acc ^ gmul(blk[i], gexp[((RS_FCR + j) * (N - 1 - i)) % 255]);
         if (acc != 8'h00) begin
            s.err = 1'b1;
            s.nz  = s.nz + 8'd1;
         end
      end
      return s;
   endfunction

   task automatic send_byte(input logic [7:0] d, input logic sop, input logic par, input logic last);
      int cyc;
      cyc = 0;
      s_axis_valid = 1'b1;
      s_axis_data = d;
      s_axis_sop = sop;
      s_axis_is_parity = par;
      s_axis_last = last;
      forever begin
         @(negedge clk);
         if (s_axis_ready) begin
            @(posedge clk); #1;
            break;
         end
         cyc++;
         if (cyc > 3000) begin
            fail_now("s_ready_timeout");
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      s_axis_valid = 1'b0;
   endtask

   task automatic send_block(input stat_t es, input int bad_last, input bit gaps);
      fwd_t f;
      exp_stat.push_back(es);
      for (int i = 0; i < N; i++) begin
         if (!TB_DROP || i < K) begin
            f.d    = blk[i];
            f.sop  = (i == 0);
            f.par  = (i >= K);
            f.last = (i == (TB_DROP ? K - 1 : N - 1));
            exp_fwd.push_back(f);
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         send_byte(blk[i], i == 0, i >= K, (i == N - 1) || (i == bad_last));
      end
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while ((exp_fwd.size() != 0 || exp_stat.size() != 0) && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 5000) fail_now("drain_timeout");
   endtask

   // Random sink back-pressure
   always @(posedge clk) begin
      #1;
      rnd_axis_rdy = ($urandom_range(0, 3) != 0);
      rnd_stat_rdy = ($urandom_range(0, 2) != 0);
   end

   // Scoreboard and hold-stability monitor, sampled mid-cycle
   logic  prev_axis_stall = 1'b0;
   fwd_t  prev_f;
   logic  prev_stat_stall = 1'b0;
   logic  prev_stat_hs = 1'b0;
   stat_t prev_s;
   always @(negedge clk) begin
      fwd_t  e;
      stat_t es;
      stat_t as;
      fwd_t  af;
      af = {m_axis_data, m_axis_sop, m_axis_is_parity, m_axis_last};
      as = {m_stat_err, 8'(m_stat_nz_cnt), tb_ferr};
      if (rst_n || mon_ignore) begin
         prev_axis_stall = 1'b0;
         prev_stat_stall = 1'b0;
         prev_stat_hs    = 1'b0;
      end else begin
         if (prev_axis_stall) chk("axis_hold", {20'h0, m_axis_valid, af}, {20'h0, 1'b1, prev_f});
         if (prev_stat_stall) chk("stat_hold", {21'h0, m_stat_valid, as}, {21'h0, 1'b1, prev_s});
         if (prev_stat_hs)    chk("stat_deassert", 32'(m_stat_valid), 32'd0);
         if (m_axis_valid && m_axis_ready) begin
            if (exp_fwd.size() == 0) begin
               chk("fwd_unexpected", 32'(af), 32'h0);
            end else begin
               e = exp_fwd.pop_front();
               chk("fwd_byte", 32'(af), 32'(e));
            end
         end
         if (m_stat_valid && m_stat_ready) begin
            stat_seen++;
            if (exp_stat.size() == 0) begin
               chk("stat_unexpected", 32'(as), 32'h0);
            end else begin
               es = exp_stat.pop_front();
               chk("stat", 32'(as), 32'(es));
            end
         end
         prev_axis_stall = m_axis_valid && !m_axis_ready;
         prev_f          = af;
         prev_stat_stall = m_stat_valid && !m_stat_ready;
         prev_stat_hs    = m_stat_valid && m_stat_ready;
         prev_s          = as;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t  tab [7];
      stat_t es;
      int    seen0;
      int    nflip;

      tab[0] = '{rnd: 1'b0, flip_pos: -1,  mask: 8'h00, err: 1'b0, nz: 0};
      tab[1] = '{rnd: 1'b1, flip_pos: -1,  mask: 8'h00, err: 1'b0, nz: 0};
      tab[2] = '{rnd: 1'b1, flip_pos: 5,   mask: 8'h01, err: 1'b1, nz: P};
      tab[3] = '{rnd: 1'b1, flip_pos: -1,  mask: 8'h00, err: 1'b0, nz: 0};
      tab[4] = '{rnd: 1'b0, flip_pos: N-1, mask: 8'h55, err: 1'b1, nz: P};
      tab[5] = '{rnd: 1'b1, flip_pos: 0,   mask: 8'h80, err: 1'b1, nz: P};
      tab[6] = '{rnd: 1'b1, flip_pos: K,   mask: 8'h3C, err: 1'b1, nz: P};

      init_gf();

      // Reset state
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready",    32'(s_axis_ready), 32'd0);
      chk("rst_m_valid",    32'(m_axis_valid), 32'd0);
      chk("rst_m_data",     32'(m_axis_data), 32'd0);
      chk("rst_m_tags",     {29'h0, m_axis_last, m_axis_sop, m_axis_is_parity}, 32'd0);
      chk("rst_stat_valid", 32'(m_stat_valid), 32'd0);
      chk("rst_stat_err",   32'(m_stat_err), 32'd0);
      chk("rst_stat_nz",    32'(m_stat_nz_cnt), 32'd0);
      chk("rst_frame_err",  32'(tb_ferr), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;

      // Directed vector table
      for (int t = 0; t < 7; t++) begin
         encode(tab[t].rnd);
         if (tab[t].flip_pos >= 0) blk[tab[t].flip_pos] = blk[tab[t].flip_pos] ^ tab[t].mask;
         es.err  = tab[t].err;
         es.nz   = 8'(tab[t].nz);
         es.ferr = 1'b0;
         send_block(es, -1, 1'b0);
      end
      drain();

      // Status held off for 20 cycles: input must stay blocked
      man_stat_rdy = 1'b0;
      es = '0;
      encode(1'b1);
      send_block(es, -1, 1'b0);
      encode(1'b1);
      s_axis_valid = 1'b1;
      s_axis_data = blk[0];
      s_axis_sop = 1'b1;
      s_axis_is_parity = 1'b0;
      s_axis_last = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("hold_s_ready",    32'(s_axis_ready), 32'd0);
         chk("hold_stat_valid", 32'(m_stat_valid), 32'd1);
         chk("hold_stat_err",   32'(m_stat_err), 32'd0);
         chk("hold_stat_nz",    32'(m_stat_nz_cnt), 32'd0);
         @(posedge clk); #1;
      end
      man_stat_rdy = 1'b1;
      send_block(es, -1, 1'b0);
      drain();

      // Reset in the middle of a block, then a clean block
      mon_ignore = 1'b1;
      encode(1'b1);
      for (int i = 0; i < 100; i++) send_byte(blk[i], i == 0, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_s_ready",    32'(s_axis_ready), 32'd0);
      chk("midrst_m_valid",    32'(m_axis_valid), 32'd0);
      chk("midrst_stat_valid", 32'(m_stat_valid), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_fwd.delete();
      exp_stat.delete();
      mon_ignore = 1'b0;
      seen0 = stat_seen;
      encode(1'b1);
      es = '0;
      send_block(es, -1, 1'b0);
      drain();
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_one_status", 32'(stat_seen - seen0), 32'd1);

`ifdef RS_FRAME_CHECK_EN
      // Early last marker flags the block; the next correct block is clean
      encode(1'b1);
      es = '0;
      es.ferr = 1'b1;
      send_block(es, 100, 1'b0);
      encode(1'b1);
      es.ferr = 1'b0;
      send_block(es, -1, 1'b0);
      drain();
`endif

      // Random blocks with random corruption, gaps and sink stalls
      stall_en = 1'b1;
      for (int b = 0; b < N_RAND; b++) begin
         encode(1'b1);
         nflip = $urandom_range(0, 3);
         for (int f = 0; f < nflip; f++) begin
            int p;
            p = $urandom_range(0, N - 1);
            blk[p] = blk[p] ^ 8'($urandom_range(1, 255));
         end
         es = model_status();
         send_block(es, -1, 1'b1);
      end
      drain();
      stall_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
